regfile_wb_arbiter: RTL and testbench

Write-back arbiter for the single write port of the 32x32 register file. It merges two write-back sources onto `rf_we`/`rf_rd`/`rf_wd`. Source A is the ALU/immediate path: high priority and zero latency. Source B is the multi-cycle path (load/CSR): buffered in a small FIFO and drained when the port is free. It also provides a pending-write scoreboard so the core can stall reads of registers with queued writes.

---
 rtl/regfile_pkg.sv | 14 +
 rtl/wb_fifo.sv | 79 +++++++
 rtl/regfile_wb_arbiter.sv | 122 ++++++++++++
 tb/tb_regfile_wb_arbiter.sv | 304 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
// Shared register-file write-back types: data width, address width, write request.
// Latency: none, types and constants only.
// Backpressure: not applicable.
package regfile_pkg;

  localparam int XLEN   = 32;
  localparam int REG_AW = 5;

  typedef struct packed {
    logic [REG_AW-1:0] rd;
    logic [XLEN-1:0]   wd;
  } wb_req_t;

endpackage

// File: rtl/wb_fifo.sv
// Small circular FIFO of write-back requests; per-slot valid bits and rds are exposed for hazard compares.
// Latency: an entry pushed at edge N is visible on head from the cycle after edge N.
// Backpressure: push is ignored while full and pop is ignored while empty; the owner gates both.
module wb_fifo
  import regfile_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          push,
  input  wb_req_t                       push_dat,
  input  logic                          pop,
  output wb_req_t                       head,
  output logic                          full,
  output logic                          empty,
  output logic [$clog2(DEPTH+1)-1:0]    count,
  output logic [DEPTH-1:0]              ent_vld,
  output logic [DEPTH-1:0][REG_AW-1:0]  ent_rd
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  wb_req_t          mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic [CW-1:0]    cnt;
  logic [DEPTH-1:0] vld;
  logic             do_push;
  logic             do_pop;

  assign full    = (cnt == CW'(DEPTH));
  assign empty   = (cnt == '0);
  assign count   = cnt;
  assign ent_vld = vld;
  assign head    = mem[rd_ptr];
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  // Slot rds flattened for the owner's associative compares.
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      ent_rd[i] = mem[i].rd;
    end
  end

  // Payload storage; contents of invalid slots are never consumed, so no reset.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= push_dat;
    end
  end

  // Pointers, occupancy and per-slot valid bits; pointers wrap naturally at power-of-2 depth.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
      vld    <= '0;
    end else begin
      if (do_pop) begin
        rd_ptr      <= rd_ptr + PW'(1);
        vld[rd_ptr] <= 1'b0;
      end
      if (do_push) begin
        wr_ptr      <= wr_ptr + PW'(1);
        vld[wr_ptr] <= 1'b1;
      end
      unique case ({do_push, do_pop})
        2'b10:   cnt <= cnt + CW'(1);
        2'b01:   cnt <= cnt - CW'(1);
        default: cnt <= cnt;
      endcase
    end
  end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Merges the zero-latency ALU write-back (A) and the FIFO-buffered multi-cycle write-back (B) onto one RF write port.
// Latency: A writes in its handshake cycle; B writes no earlier than the cycle after its push.
// Backpressure: a_ready drops on WAW against a queued rd or when the FIFO head is starved; b_ready drops when full.
module regfile_wb_arbiter
  import regfile_pkg::*;
#(
  parameter int DEPTH        = 2,
  parameter int STARVE_LIMIT = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              a_valid,
  output logic              a_ready,
  input  logic [REG_AW-1:0] a_rd,
  input  logic [XLEN-1:0]   a_wd,
  input  logic              b_valid,
  output logic              b_ready,
  input  logic [REG_AW-1:0] b_rd,
  input  logic [XLEN-1:0]   b_wd,
  output logic              rf_we,
  output logic [REG_AW-1:0] rf_rd,
  output logic [XLEN-1:0]   rf_wd,
  input  logic [REG_AW-1:0] q_rs1,
  input  logic [REG_AW-1:0] q_rs2,
  output logic              busy_rs1,
  output logic              busy_rs2
);

  localparam int CW = $clog2(DEPTH+1);
  localparam int WW = $clog2(STARVE_LIMIT+1);

  wb_req_t                     head;
  logic                        fifo_full;
  logic                        fifo_empty;
  logic [CW-1:0]               fifo_count;
  logic [DEPTH-1:0]            ent_vld;
  logic [DEPTH-1:0][REG_AW-1:0] ent_rd;
  logic [WW-1:0]               wait_cnt;
  logic                        starved;
  logic                        a_waw;
  logic                        a_grant;
  logic                        b_pop;
  logic                        b_push;

  // True when a nonzero rd has a write still sitting in the FIFO.
  function automatic logic fifo_holds(input logic [REG_AW-1:0]           rd,
                                      input logic [DEPTH-1:0]            vld,
                                      input logic [DEPTH-1:0][REG_AW-1:0] rds);
    logic hit;
    hit = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (vld[i] && (rds[i] == rd)) hit = 1'b1;
    end
    return hit && (rd != '0);
  endfunction

  wb_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .push     (b_push),
    .push_dat ('{rd: b_rd, wd: b_wd}),
    .pop      (b_pop),
    .head     (head),
    .full     (fifo_full),
    .empty    (fifo_empty),
    .count    (fifo_count),
    .ent_vld  (ent_vld),
    .ent_rd   (ent_rd)
  );

  // Grant: a starved head beats A; A wins unless WAW-blocked; otherwise the head drains.
  always_comb begin
    starved  = !fifo_empty && (wait_cnt >= WW'(STARVE_LIMIT));
    a_waw    = fifo_holds(a_rd, ent_vld, ent_rd);
    a_ready  = !starved && !a_waw;
    a_grant  = a_valid && a_ready;
    b_pop    = !fifo_empty && !a_grant;
    b_ready  = (fifo_count < CW'(DEPTH));
    b_push   = b_valid && b_ready;
    busy_rs1 = fifo_holds(q_rs1, ent_vld, ent_rd);
    busy_rs2 = fifo_holds(q_rs2, ent_vld, ent_rd);
  end

  // Write-port mux; rd=0 still consumes its grant but never asserts the strobe.
  always_comb begin
    rf_we = 1'b0;
    rf_rd = '0;
    rf_wd = '0;
    if (!rst) begin
      if (a_grant) begin
        if (a_rd != '0) begin
          rf_we = 1'b1;
          rf_rd = a_rd;
          rf_wd = a_wd;
        end
      end else if (b_pop && (head.rd != '0)) begin
        rf_we = 1'b1;
        rf_rd = head.rd;
        rf_wd = head.wd;
      end
    end
  end

  // Count cycles the head has been passed over; saturates so the force condition holds.
  always_ff @(posedge clk) begin
    if (rst) begin
      wait_cnt <= '0;
    end else if (b_pop) begin
      wait_cnt <= '0;
    end else if (!fifo_empty && (wait_cnt < WW'(STARVE_LIMIT))) begin
      wait_cnt <= wait_cnt + WW'(1);
    end
  end

  // Occupancy flags from the FIFO must agree with its count.
  always_ff @(posedge clk) begin
    if (!rst) begin
      assert (fifo_full == (fifo_count == CW'(DEPTH)));
    end
  end

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Scoreboard bench for regfile_wb_arbiter: directed scenarios followed by randomized traffic.
// Latency: a queue-based reference predicts each cycle's write and handshake levels.
// Backpressure: stimulus honours a_ready/b_ready exactly as the reference predicts.
module tb_regfile_wb_arbiter;

  localparam int DEPTH        = 2;
  localparam int STARVE_LIMIT = 4;

  typedef struct {
    logic [4:0]  rd;
    logic [31:0] wd;
  } wr_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        a_valid, a_ready, b_valid, b_ready;
  logic [4:0]  a_rd, b_rd, q_rs1, q_rs2, rf_rd;
  logic [31:0] a_wd, b_wd, rf_wd;
  logic        rf_we, busy_rs1, busy_rs2;

  int checks = 0;
  int errors = 0;

  wr_t         fifo_m[$];
  wr_t         exp_q[$];
  int          wait_m = 0;
  logic [31:0] ref_regs [32];
  logic [31:0] dut_regs [32];

  regfile_wb_arbiter #(.DEPTH(DEPTH), .STARVE_LIMIT(STARVE_LIMIT)) dut (
    .clk(clk), .rst(rst),
    .a_valid(a_valid), .a_ready(a_ready), .a_rd(a_rd), .a_wd(a_wd),
    .b_valid(b_valid), .b_ready(b_ready), .b_rd(b_rd), .b_wd(b_wd),
    .rf_we(rf_we), .rf_rd(rf_rd), .rf_wd(rf_wd),
    .q_rs1(q_rs1), .q_rs2(q_rs2), .busy_rs1(busy_rs1), .busy_rs2(busy_rs2)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit in_fifo(input logic [4:0] r);
    if (r == 5'd0) return 1'b0;
    foreach (fifo_m[i]) if (fifo_m[i].rd == r) return 1'b1;
    return 1'b0;
  endfunction

  task automatic record(input logic [4:0] rd, input logic [31:0] wd);
    wr_t w;
    w.rd = rd;
    w.wd = wd;
    exp_q.push_back(w);
    ref_regs[rd] = wd;
  endtask

  // Reference: one queue of pending B writes plus a pass-over counter, stepped once per cycle.
  task automatic model_step();
    wr_t h;
    wr_t nb;
    bit  nonempty, force_b, ar, br, popped;
    if (rst) begin
      fifo_m.delete();
      wait_m = 0;
      return;
    end
    nonempty = (fifo_m.size() != 0);
    force_b  = nonempty && (wait_m >= STARVE_LIMIT);
    ar       = !force_b && !in_fifo(a_rd);
    br       = (fifo_m.size() < DEPTH);
    chk1("a_ready", a_ready, ar);
    chk1("b_ready", b_ready, br);
    chk1("busy_rs1", busy_rs1, in_fifo(q_rs1));
    chk1("busy_rs2", busy_rs2, in_fifo(q_rs2));
    popped = 1'b0;
    if (a_valid && ar) begin
      if (a_rd != 5'd0) record(a_rd, a_wd);
    end else if (nonempty) begin
      h = fifo_m.pop_front();
      popped = 1'b1;
      if (h.rd != 5'd0) record(h.rd, h.wd);
    end
    if (popped) wait_m = 0;
    else if (nonempty && wait_m < STARVE_LIMIT) wait_m++;
    if (b_valid && br) begin
      nb.rd = b_rd;
      nb.wd = b_wd;
      fifo_m.push_back(nb);
    end
  endtask

  initial begin
    forever begin
      @(posedge clk);
      #3;
      model_step();
    end
  end

  // Monitor: every strobe must match the oldest predicted write; idle cycles must be quiet.
  initial begin
    wr_t e;
    forever begin
      @(negedge clk);
      if (rst) begin
        chk1("rf_we_in_reset", rf_we, 1'b0);
      end else if (rf_we) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_write: got rd=%0d wd=0x%0h expected none at %0t", rf_rd, rf_wd, $time);
        end else begin
          e = exp_q.pop_front();
          chk("wb_rd", 32'(rf_rd), 32'(e.rd));
          chk("wb_wd", rf_wd, e.wd);
        end
        dut_regs[rf_rd] = rf_wd;
      end else begin
        chk("missed_write", 32'(exp_q.size()), 32'd0);
        exp_q.delete();
        chk("idle_rd", 32'(rf_rd), 32'd0);
        chk("idle_wd", rf_wd, 32'd0);
      end
    end
  end

  task automatic set_in(input logic av, input logic [4:0] ard, input logic [31:0] awd,
                        input logic bv, input logic [4:0] brd, input logic [31:0] bwd);
    a_valid = av; a_rd = ard; a_wd = awd;
    b_valid = bv; b_rd = brd; b_wd = bwd;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    for (int i = 0; i < 32; i++) begin
      ref_regs[i] = 32'd0;
      dut_regs[i] = 32'd0;
    end
    rst = 1'b1;
    q_rs1 = 5'd5;
    q_rs2 = 5'd0;
    set_in(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);

    // Reset values
    repeat (2) tick();
    rst = 1'b0;
    #1;
    chk1("reset_rf_we", rf_we, 1'b0);
    chk1("reset_a_ready", a_ready, 1'b1);
    chk1("reset_b_ready", b_ready, 1'b1);
    chk1("reset_busy_rs1", busy_rs1, 1'b0);
    tick();

    // A only: zero latency, then rd=0 accepted without a strobe
    set_in(1'b1, 5'd5, 32'h0000_0011, 1'b0, 5'd0, 32'd0);
    #1;
    chk1("a_rf_we", rf_we, 1'b1);
    chk("a_rf_rd", 32'(rf_rd), 32'd5);
    chk("a_rf_wd", rf_wd, 32'h11);
    tick();
    set_in(1'b1, 5'd0, 32'h99, 1'b0, 5'd0, 32'd0);
    #1;
    chk1("a_rd0_ready", a_ready, 1'b1);
    chk1("a_rd0_we", rf_we, 1'b0);
    tick();

    // B only: busy between push and write, cleared afterwards
    q_rs1 = 5'd7;
    set_in(1'b0, 5'd0, 32'd0, 1'b1, 5'd7, 32'hAAAA_5555);
    #1;
    chk1("b_busy_before", busy_rs1, 1'b0);
    tick();
    set_in(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    #1;
    chk1("b_busy_pending", busy_rs1, 1'b1);
    chk1("b_rf_we", rf_we, 1'b1);
    chk("b_rf_rd", 32'(rf_rd), 32'd7);
    chk("b_rf_wd", rf_wd, 32'hAAAA_5555);
    tick();
    #1;
    chk1("b_busy_after", busy_rs1, 1'b0);

    // Full FIFO: A keeps winning so two B entries accumulate
    set_in(1'b1, 5'd1, 32'h101, 1'b1, 5'd10, 32'hB0);
    tick();
    set_in(1'b1, 5'd2, 32'h102, 1'b1, 5'd11, 32'hB1);
    tick();
    set_in(1'b1, 5'd4, 32'h104, 1'b1, 5'd12, 32'hB2);
    #1;
    chk1("full_b_ready", b_ready, 1'b0);
    chk("full_a_wins", 32'(rf_rd), 32'd4);
    tick();
    set_in(1'b0, 5'd0, 32'd0, 1'b1, 5'd12, 32'hB2);
    #1;
    chk1("full_pop_b_ready", b_ready, 1'b0);
    chk("full_pop_rd", 32'(rf_rd), 32'd10);
    tick();
    #1;
    chk1("after_pop_b_ready", b_ready, 1'b1);
    chk("second_pop_rd", 32'(rf_rd), 32'd11);
    tick();
    set_in(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    repeat (3) tick();

    // Starvation: head rd=9 loses four cycles to A, then is forced
    set_in(1'b0, 5'd0, 32'd0, 1'b1, 5'd9, 32'h99);
    tick();
    for (int i = 1; i <= 6; i++) begin
      set_in(1'b1, 5'(i), 32'(i * 16), 1'b0, 5'd0, 32'd0);
      #1;
      if (i == 5) begin
        chk1("starve_a_ready", a_ready, 1'b0);
        chk("starve_rd", 32'(rf_rd), 32'd9);
      end else begin
        chk1("stream_a_ready", a_ready, 1'b1);
        chk("stream_rd", 32'(rf_rd), 32'(i));
      end
      tick();
    end
    set_in(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    tick();

    // WAW: A waits for the older queued write to the same register
    set_in(1'b0, 5'd0, 32'd0, 1'b1, 5'd3, 32'h1);
    tick();
    set_in(1'b1, 5'd3, 32'h2, 1'b0, 5'd0, 32'd0);
    #1;
    chk1("waw_a_ready", a_ready, 1'b0);
    chk("waw_old_wd", rf_wd, 32'h1);
    tick();
    #1;
    chk1("waw_a_resume", a_ready, 1'b1);
    chk("waw_new_wd", rf_wd, 32'h2);
    tick();
    set_in(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    tick();
    chk("waw_final_reg3", dut_regs[3], 32'h2);

    // Reset with two queued entries: they must be discarded
    set_in(1'b1, 5'd1, 32'h201, 1'b1, 5'd20, 32'hC0);
    tick();
    set_in(1'b1, 5'd2, 32'h202, 1'b1, 5'd21, 32'hC1);
    tick();
    set_in(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    q_rs1 = 5'd20;
    q_rs2 = 5'd21;
    rst = 1'b1;
    repeat (2) tick();
    rst = 1'b0;
    #1;
    chk1("flush_busy_rs1", busy_rs1, 1'b0);
    chk1("flush_busy_rs2", busy_rs2, 1'b0);
    chk1("flush_b_ready", b_ready, 1'b1);
    for (int i = 0; i < 4; i++) begin
      chk1("flush_no_write", rf_we, 1'b0);
      tick();
    end

    // Randomized traffic with small rd range for frequent hazards
    for (int n = 0; n < 3000; n++) begin
      int a_pct;
      a_pct = ((n / 500) % 2 == 1) ? 95 : 55;
      rst     = ($urandom_range(0, 199) == 0);
      a_valid = ($urandom_range(0, 99) < a_pct);
      a_rd    = 5'($urandom_range(0, 7));
      a_wd    = $urandom;
      b_valid = ($urandom_range(0, 99) < 50);
      b_rd    = 5'($urandom_range(0, 7));
      b_wd    = $urandom;
      q_rs1   = 5'($urandom_range(0, 7));
      q_rs2   = 5'($urandom_range(0, 7));
      tick();
    end
    rst = 1'b0;
    set_in(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    repeat (8) tick();

    chk("final_pending", 32'(exp_q.size()), 32'd0);
    for (int i = 0; i < 32; i++) begin
      chk("final_reg", dut_regs[i], ref_regs[i]);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
